serial_chunk_adder: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first.
- Carry is held in a register between chunks, so hardware cost is one CHUNK-bit ripple stage regardless of WIDTH.
- Successor to the fixed 2/4/6-bit combinational ripple adders.
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake for use by multi-cycle datapaths (ALU, accumulator).

---
 rtl/serial_chunk_adder_pkg.sv | 23 ++
 rtl/serial_chunk_adder_chunk_adder.sv | 28 ++
 rtl/serial_chunk_adder.sv | 99 +++++++++
 tb/tb_serial_chunk_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// rtl/serial_chunk_adder_pkg.sv - shared types and sizing helpers for the serial chunk adder
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_chunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int N_CHUNK   = n_chunk(DEF_WIDTH, DEF_CHUNK);
    localparam int CNT_W     = cnt_width(N_CHUNK);

endpackage

// File: rtl/serial_chunk_adder_chunk_adder.sv
// rtl/serial_chunk_adder_chunk_adder.sv - combinational CHUNK-bit ripple stage
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic cy;

    // c_msb is the carry entering the top bit; the top level uses it for signed overflow
    always_comb begin
        cy    = cin;
        c_msb = cin;
        sum   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = cy;
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = n_chunk(WIDTH, CHUNK);
    localparam int CW = cnt_width(N);

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_sr, y_sr, res, res_next;
    logic             carry;
    logic             accept, last;
    logic [CHUNK-1:0] sum;
    logic             cout, c_msb;

    assign accept = start && (state != BUSY);
    assign last   = (cnt == CW'(N - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (x_sr[CHUNK-1:0]),
        .b    (y_sr[CHUNK-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout),
        .c_msb(c_msb)
    );

    // Each new chunk enters at the top, so after N shifts the result is aligned
    assign res_next = (res >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last)  state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            x_sr  <= '0;
            y_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            out   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction is x + ~y + 1 (or + 0 when a borrow comes in)
            x_sr  <= x;
            y_sr  <= sub ? ~y : y;
            carry <= c_in ^ sub;
            cnt   <= '0;
        end else if (state == BUSY) begin
            x_sr  <= x_sr >> CHUNK;
            y_sr  <= y_sr >> CHUNK;
            res   <= res_next;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cnt   <= '0;
                out   <= res_next;
                c_out <= cout;
                ovf   <= c_msb ^ cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - randomized self-checking bench over CHUNK=4, 16 and 1
module tb_serial_chunk_adder;

    logic        clk;
    logic        reset;
    logic [2:0]  start;
    logic        sub;
    logic [15:0] x, y;
    logic        c_in;
    logic [2:0]  busy_w, done_w, c_out_w, ovf_w;
    logic [15:0] out_w [3];

    int n_checks = 0;
    int n_fail   = 0;
    int ns [3];
    logic [15:0] prev_out [3];
    logic        prev_c   [3];
    logic        prev_v   [3];

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .sub(sub), .x(x), .y(y), .c_in(c_in),
        .busy(busy_w[0]), .done(done_w[0]), .out(out_w[0]), .c_out(c_out_w[0]), .ovf(ovf_w[0]));
    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .sub(sub), .x(x), .y(y), .c_in(c_in),
        .busy(busy_w[1]), .done(done_w[1]), .out(out_w[1]), .c_out(c_out_w[1]), .ovf(ovf_w[1]));
    serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .sub(sub), .x(x), .y(y), .c_in(c_in),
        .busy(busy_w[2]), .done(done_w[2]), .out(out_w[2]), .c_out(c_out_w[2]), .ovf(ovf_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signed and unsigned views of the same operation, computed with plain integers
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                  input logic s, output logic [15:0] r, output logic co,
                                  output logic ov);
        int ua, ub, sa, sb, si, c;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = int'(ci);
        if (!s) begin
            r  = 16'(ua + ub + c);
            co = (ua + ub + c) > 65535;
            si = sa + sb + c;
        end else begin
            r  = 16'(ua - ub - c);
            co = ua >= (ub + c);
            si = sa - sb - c;
        end
        ov = (si > 32767) || (si < -32768);
    endfunction

    task automatic clear_prev();
        for (int i = 0; i < 3; i++) begin
            prev_out[i] = '0;
            prev_c[i]   = 1'b0;
            prev_v[i]   = 1'b0;
        end
    endtask

    // Caller has driven start/operands just after a falling edge
    task automatic run(input logic [2:0] mask, input bit poke, input bit chain,
                       input logic [15:0] nx, input logic [15:0] ny, input logic ncin,
                       input logic nsub);
        logic [15:0] eo;
        logic        ec, ev;
        int          kmax;
        model(x, y, c_in, sub, eo, ec, ev);
        kmax = mask[2] ? 18 : (mask[0] ? 6 : 3);
        @(posedge clk);
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (mask[i]) begin
                    check($sformatf("busy%0d_k%0d", i, k), 32'(busy_w[i]), 32'(k <= ns[i]));
                    check($sformatf("done%0d_k%0d", i, k), 32'(done_w[i]), 32'(k == ns[i] + 1));
                    if (k <= ns[i]) begin
                        check($sformatf("hold_out%0d_k%0d", i, k), 32'(out_w[i]), 32'(prev_out[i]));
                        check($sformatf("hold_cv%0d_k%0d", i, k), 32'({c_out_w[i], ovf_w[i]}),
                              32'({prev_c[i], prev_v[i]}));
                    end else begin
                        check($sformatf("out%0d_k%0d", i, k), 32'(out_w[i]), 32'(eo));
                        check($sformatf("c_out%0d_k%0d", i, k), 32'(c_out_w[i]), 32'(ec));
                        check($sformatf("ovf%0d_k%0d", i, k), 32'(ovf_w[i]), 32'(ev));
                        prev_out[i] = eo;
                        prev_c[i]   = ec;
                        prev_v[i]   = ev;
                    end
                end
            end
            if (k == 1) begin
                start = '0;
                x     = 16'($urandom);
                y     = 16'($urandom);
                c_in  = 1'($urandom);
                sub   = 1'($urandom);
            end
            if (poke && k == 2) start[0] = 1'b1;
            if (poke && k == 3) start[0] = 1'b0;
            if (chain && k == ns[0] + 1) begin
                start[0] = 1'b1;
                x        = nx;
                y        = ny;
                c_in     = ncin;
                sub      = nsub;
                return;
            end
        end
    endtask

    task automatic op(input logic [2:0] mask, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic s);
        x     = a;
        y     = b;
        c_in  = ci;
        sub   = s;
        start = mask;
        run(mask, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        ns[0] = 4;
        ns[1] = 1;
        ns[2] = 16;
        clear_prev();
        reset = 1'b1;
        start = '0;
        sub   = 1'b0;
        x     = '0;
        y     = '0;
        c_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'(0));
            check($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'(0));
            check($sformatf("rst_out%0d", i), 32'(out_w[i]), 32'(0));
            check($sformatf("rst_cv%0d", i), 32'({c_out_w[i], ovf_w[i]}), 32'(0));
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", 32'(busy_w), 32'(0));
            check("idle_done", 32'(done_w), 32'(0));
        end

        op(3'b111, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        op(3'b111, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(3'b111, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(3'b111, 16'h0005, 16'h0007, 1'b0, 1'b1);
        op(3'b111, 16'h8000, 16'h0001, 1'b0, 1'b1);
        op(3'b111, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
        op(3'b111, 16'h8000, 16'h8000, 1'b1, 1'b0);
        op(3'b111, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // start pulsed mid-operation with fresh operands must be ignored
        x = 16'h4321; y = 16'h1111; c_in = 1'b1; sub = 1'b0; start = 3'b001;
        run(3'b001, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // start during DONE is accepted back-to-back
        x = 16'h1000; y = 16'h2000; c_in = 1'b0; sub = 1'b0; start = 3'b001;
        run(3'b001, 1'b0, 1'b1, 16'h0003, 16'h0009, 1'b1, 1'b1);
        run(3'b001, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        // reset in the middle of an operation aborts without a done pulse
        x = 16'h00FF; y = 16'h0F0F; c_in = 1'b0; sub = 1'b0; start = 3'b001;
        @(posedge clk);
        @(negedge clk);
        start = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_w[0]), 32'(0));
        check("abort_done", 32'(done_w[0]), 32'(0));
        check("abort_out", 32'(out_w[0]), 32'(0));
        reset = 1'b0;
        clear_prev();
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_w[0]), 32'(0));
            check("abort_no_busy", 32'(busy_w[0]), 32'(0));
        end

        for (int n = 0; n < 40; n++)
            op(3'b111, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
